// File: rtl/button_event_gen_if.sv
// Event stream between button_event_gen (master) and its consumer (slave).
//   evt_valid : head event available (FIFO not empty)
//   evt_ready : consumer accepts the head event when high together with evt_valid
//   evt_data  : {type[1:0], idx[1:0]}; type 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   evt_count : FIFO occupancy, 0..4
interface button_event_gen_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_data;
  logic [2:0] evt_count;

  modport master (
    output evt_valid,
    output evt_data,
    output evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_count,
    output evt_ready
  );
endinterface

// File: rtl/button_event_gen.sv
// Turns four debounced button levels into PRESS / RELEASE / LONG / REPEAT events,
// queued through a 4-entry show-ahead FIFO.
//   clk       : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   btn_state : debounced button levels, active high, synchronous to clk
//   evt       : event stream (master side of button_event_gen_if)
//   ovf       : sticky, set when an event is lost because its pending bit was still set
module button_event_gen #(
  parameter int unsigned LONG_CYC = 50_000_000,
  parameter int unsigned REP_CYC  = 10_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                btn_state,
  button_event_gen_if.master        evt,
  output logic                      ovf
);

  typedef enum logic [1:0] {StIdle, StHeld, StLongHeld} btn_st_e;

  localparam logic [26:0] LongLast = 27'(LONG_CYC - 1);
  localparam logic [26:0] RepLast  = 27'(REP_CYC - 1);

  btn_st_e     st_q   [4];
  btn_st_e     st_d   [4];
  logic [26:0] cnt_q  [4];
  logic [26:0] cnt_d  [4];
  logic [3:0]  mem_q  [4];
  logic [3:0]  mem_d  [4];
  logic [3:0]  prev_q;
  logic [15:0] pend_q, pend_d, pend_set, pend_clr, grant;
  logic        ovf_q, ovf_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        found, push, pop;
  logic [3:0]  push_data;

  // Per-button FSMs. Pending bit index is idx*4 + type.
  always_comb begin
    pend_set = '0;
    for (int i = 0; i < 4; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        StIdle: begin
          if (btn_state[i] && !prev_q[i]) begin
            st_d[i]         = StHeld;
            cnt_d[i]        = '0;
            pend_set[i*4+0] = 1'b1;
          end
        end
        StHeld, StLongHeld: begin
          // Release wins over a LONG/REPEAT falling due on the same cycle.
          if (!btn_state[i] && prev_q[i]) begin
            st_d[i]         = StIdle;
            cnt_d[i]        = '0;
            pend_set[i*4+1] = 1'b1;
          end else if (st_q[i] == StHeld && cnt_q[i] == LongLast) begin
            st_d[i]         = StLongHeld;
            cnt_d[i]        = '0;
            pend_set[i*4+2] = 1'b1;
          end else if (st_q[i] == StLongHeld && cnt_q[i] == RepLast) begin
            cnt_d[i]        = '0;
            pend_set[i*4+3] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 27'd1;
          end
        end
        default: begin
          st_d[i]  = StIdle;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Arbiter: lowest pending bit wins, which gives lowest idx first, then type order.
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    push_data = '0;
    for (int b = 0; b < 16; b++) begin
      if (pend_q[b] && !found) begin
        found     = 1'b1;
        grant[b]  = 1'b1;
        push_data = {2'(b % 4), 2'(b / 4)};
      end
    end
  end

  assign pop  = (count_q != 3'd0) && evt.evt_ready;
  assign push = found && ((count_q != 3'd4) || pop);

  always_comb begin
    pend_clr = push ? grant : '0;
    // Clearing before setting lets a re-set in the same cycle survive without overflow.
    pend_d   = (pend_q & ~pend_clr) | pend_set;
    ovf_d    = ovf_q | (|(pend_set & pend_q & ~pend_clr));

    for (int e = 0; e < 4; e++) mem_d[e] = mem_q[e];
    // When full with a pop, wr_ptr equals rd_ptr: overwriting the slot being popped is safe.
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b0, push} - {2'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
        mem_q[i] <= '0;
      end
    end else begin
      prev_q   <= btn_state;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign evt.evt_valid = (count_q != 3'd0);
  assign evt.evt_data  = mem_q[rd_ptr_q];
  assign evt.evt_count = count_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_button_event_gen.sv
module tb_button_event_gen;
  localparam int unsigned LongCyc = 8;
  localparam int unsigned RepCyc  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_state = '0;
  logic       ovf;

  button_event_gen_if evt_if ();

  button_event_gen #(
    .LONG_CYC (LongCyc),
    .REP_CYC  (RepCyc)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_state (btn_state),
    .evt       (evt_if.master),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: events derived from the time a button has been held.
  int          m_age [4];
  logic [3:0]  m_prev;
  logic [15:0] m_pend;
  logic [3:0]  m_q [$];
  logic        m_ovf;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_age[i] = 0;
    m_prev = '0;
    m_pend = '0;
    m_q.delete();
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] btn, input logic rdy);
    bit m_pop, m_push;
    int sel, t;
    m_pop = (m_q.size() > 0) && rdy;
    sel = -1;
    for (int b = 0; b < 16; b++) if (m_pend[b] && sel < 0) sel = b;
    m_push = (sel >= 0) && ((m_q.size() < 4) || m_pop);
    if (m_push) m_pend[sel] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = -1;
      if (btn[i] && !m_prev[i]) begin
        t = 0;
        m_age[i] = 0;
      end else if (!btn[i] && m_prev[i]) begin
        t = 1;
      end else if (btn[i] && m_prev[i]) begin
        m_age[i]++;
        if (m_age[i] == int'(LongCyc)) t = 2;
        else if (m_age[i] > int'(LongCyc) && ((m_age[i] - int'(LongCyc)) % int'(RepCyc)) == 0)
          t = 3;
      end
      if (t >= 0) begin
        if (m_pend[i*4+t]) m_ovf = 1'b1;
        else m_pend[i*4+t] = 1'b1;
      end
    end
    m_prev = btn;
    if (m_pop) void'(m_q.pop_front());
    if (m_push) m_q.push_back({2'(sel % 4), 2'(sel / 4)});
  endtask

  // One clock: model follows the same inputs, outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge(btn_state, evt_if.evt_ready);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, {7'd0, evt_if.evt_valid}, 8'd0);
    chk({tag, "_rst_count"}, {5'd0, evt_if.evt_count}, 8'd0);
    chk({tag, "_rst_ovf"}, {7'd0, ovf}, 8'd0);
    chk({tag, "_rst_data"}, {4'd0, evt_if.evt_data}, 8'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic       ev;
    logic [3:0] ed;
    logic [2:0] ec;
    logic       eo;
  } vec_t;

  vec_t tbl [18];

  int         log_c [$];
  logic [3:0] log_d [$];

  // Hold button idx for 'hold' cycles with ready high, log every visible event.
  task automatic hold_seq(input int idx, input int hold, input int ncyc);
    log_c.delete();
    log_d.delete();
    evt_if.evt_ready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      btn_state = (c < hold) ? 4'(1 << idx) : 4'h0;
      step();
      if (evt_if.evt_valid) begin
        log_c.push_back(c);
        log_d.push_back(evt_if.evt_data);
      end
    end
  endtask

  initial begin
    int         exp_c [5];
    logic [3:0] exp_d [5];

    // Four simultaneous presses, then fill the FIFO, overflow on btn 1.
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 4'h0, 3'd1, 1'b0};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 4'h1, 3'd1, 1'b0};
    tbl[3]  = '{4'hF, 1'b1, 1'b1, 4'h2, 3'd1, 1'b0};
    tbl[4]  = '{4'hF, 1'b1, 1'b1, 4'h3, 3'd1, 1'b0};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[6]  = '{4'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
    tbl[7]  = '{4'h1, 1'b0, 1'b1, 4'h4, 3'd1, 1'b0};
    tbl[8]  = '{4'h1, 1'b0, 1'b1, 4'h4, 3'd2, 1'b0};
    tbl[9]  = '{4'h1, 1'b0, 1'b1, 4'h4, 3'd3, 1'b0};
    tbl[10] = '{4'h1, 1'b0, 1'b1, 4'h4, 3'd4, 1'b0};
    tbl[11] = '{4'h1, 1'b0, 1'b1, 4'h4, 3'd4, 1'b0};
    tbl[12] = '{4'h1, 1'b1, 1'b1, 4'h0, 3'd4, 1'b0};
    tbl[13] = '{4'h1, 1'b0, 1'b1, 4'h0, 3'd4, 1'b0};
    tbl[14] = '{4'h3, 1'b0, 1'b1, 4'h0, 3'd4, 1'b0};
    tbl[15] = '{4'h1, 1'b0, 1'b1, 4'h0, 3'd4, 1'b0};
    tbl[16] = '{4'h3, 1'b0, 1'b1, 4'h0, 3'd4, 1'b1};
    tbl[17] = '{4'h1, 1'b0, 1'b1, 4'h0, 3'd4, 1'b1};

    evt_if.evt_ready = 1'b1;
    model_reset();
    do_reset("init");

    for (int r = 0; r < 18; r++) begin
      btn_state        = tbl[r].btn;
      evt_if.evt_ready = tbl[r].rdy;
      step();
      chk($sformatf("tbl%0d_valid", r), {7'd0, evt_if.evt_valid}, {7'd0, tbl[r].ev});
      chk($sformatf("tbl%0d_count", r), {5'd0, evt_if.evt_count}, {5'd0, tbl[r].ec});
      chk($sformatf("tbl%0d_ovf", r), {7'd0, ovf}, {7'd0, tbl[r].eo});
      if (tbl[r].ev)
        chk($sformatf("tbl%0d_data", r), {4'd0, evt_if.evt_data}, {4'd0, tbl[r].ed});
    end

    // Reset in the middle of a long hold; the hold must not resume.
    do_reset("midhold");
    btn_state = 4'h0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("after_reset_idle", {7'd0, evt_if.evt_valid}, 8'd0);
    end

    // LONG / REPEAT timing on btn 0.
    hold_seq(0, 20, 26);
    exp_c = '{1, 9, 13, 17, 21};
    exp_d = '{4'b0000, 4'b1000, 4'b1100, 4'b1100, 4'b0100};
    chk("long_n_events", 8'(log_c.size()), 8'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < log_c.size()) begin
        chk($sformatf("long_ev%0d_cycle", k), 8'(log_c[k]), 8'(exp_c[k]));
        chk($sformatf("long_ev%0d_data", k), {4'd0, log_d[k]}, {4'd0, exp_d[k]});
      end
    end
    chk("long_ovf", {7'd0, ovf}, 8'd0);

    // Short press/release on btn 2: visible one edge after each sampled change.
    hold_seq(2, 6, 10);
    chk("short_n_events", 8'(log_c.size()), 8'd2);
    if (log_c.size() >= 2) begin
      chk("short_press_cycle", 8'(log_c[0]), 8'd1);
      chk("short_press_data", {4'd0, log_d[0]}, 8'b0010);
      chk("short_rel_cycle", 8'(log_c[1]), 8'd7);
      chk("short_rel_data", {4'd0, log_d[1]}, 8'b0110);
    end
    chk("short_ovf", {7'd0, ovf}, 8'd0);

    // Randomised run against the reference model, with periodic resets.
    do_reset("rnd0");
    for (int c = 0; c < 4000; c++) begin
      if (c % 700 == 699) do_reset("rnd");
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 15) == 0) btn_state[i] = ~btn_state[i];
      if ((c / 150) % 2 == 0) evt_if.evt_ready = ($urandom_range(0, 9) < 7);
      else evt_if.evt_ready = ($urandom_range(0, 9) < 2);
      step();
      chk("rnd_valid", {7'd0, evt_if.evt_valid}, {7'd0, (m_q.size() != 0)});
      chk("rnd_count", {5'd0, evt_if.evt_count}, 8'(m_q.size()));
      chk("rnd_ovf", {7'd0, ovf}, {7'd0, m_ovf});
      if (m_q.size() != 0) chk("rnd_data", {4'd0, evt_if.evt_data}, {4'd0, m_q[0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
